// File: rtl/uart_txrx_top.sv
// Full-duplex 8N1 UART: registered transmitter and a synchronized,
// mid-bit sampling receiver sharing one clock and baud setting.
module uart_txrx_top #(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  input  logic       tx_start,
  input  logic [7:0] tx_data_in,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
  } rx_state_t;

  tx_state_t     tx_st, tx_st_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_idx, tx_idx_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          tx_q, tx_q_n;
  logic          tx_last;

  assign tx_last = (tx_cnt == LAST);
  assign tx      = tx_q;
  assign tx_done = ~rst & (tx_st == TX_STOP) & tx_last;
  // a start in the done cycle chains frames, so busy never drops then
  assign tx_busy = ~rst & (tx_st != TX_IDLE)
                 & ~(tx_done & ~tx_start);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx_q   <= 1'b1;
    end else begin
      tx_st  <= tx_st_n;
      tx_cnt <= tx_cnt_n;
      tx_idx <= tx_idx_n;
      tx_sh  <= tx_sh_n;
      tx_q   <= tx_q_n;
    end
  end

  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt + CW'(1);
    tx_idx_n = tx_idx;
    tx_sh_n  = tx_sh;
    tx_q_n   = tx_q;
    unique case (tx_st)
      TX_IDLE: begin
        tx_cnt_n = '0;
        tx_q_n   = 1'b1;
        if (tx_start) begin
          tx_st_n = TX_START;
          tx_sh_n = tx_data_in;
          tx_q_n  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_last) begin
          tx_cnt_n = '0;
          tx_idx_n = '0;
          tx_st_n  = TX_DATA;
          tx_q_n   = tx_sh[0];
        end
      end
      TX_DATA: begin
        if (tx_last) begin
          tx_cnt_n = '0;
          if (tx_idx == 3'd7) begin
            tx_st_n = TX_STOP;
            tx_q_n  = 1'b1;
          end else begin
            tx_idx_n = tx_idx + 3'd1;
            tx_sh_n  = {1'b0, tx_sh[7:1]};
            tx_q_n   = tx_sh[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_last) begin
          tx_cnt_n = '0;
          if (tx_start) begin
            tx_st_n = TX_START;
            tx_sh_n = tx_data_in;
            tx_q_n  = 1'b0;
          end else begin
            tx_st_n = TX_IDLE;
            tx_q_n  = 1'b1;
          end
        end
      end
      default: tx_st_n = TX_IDLE;
    endcase
  end

  logic          rx_s1, rx_s2;
  rx_state_t     rx_st, rx_st_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_idx, rx_idx_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic [7:0]    rx_data_n;
  logic          rx_done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      rx_idx  <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      rx_done <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_st   <= rx_st_n;
      rx_cnt  <= rx_cnt_n;
      rx_idx  <= rx_idx_n;
      rx_sh   <= rx_sh_n;
      rx_data <= rx_data_n;
      rx_done <= rx_done_n;
    end
  end

  always_comb begin
    rx_st_n   = rx_st;
    rx_cnt_n  = rx_cnt + CW'(1);
    rx_idx_n  = rx_idx;
    rx_sh_n   = rx_sh;
    rx_data_n = rx_data;
    rx_done_n = 1'b0;
    unique case (rx_st)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_s2) rx_st_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == MID) begin
          rx_cnt_n = '0;
          rx_idx_n = '0;
          rx_st_n  = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          if (rx_idx == 3'd7) rx_st_n = RX_STOP;
          else rx_idx_n = rx_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n = '0;
          if (rx_s2) begin
            rx_data_n = rx_sh;
            rx_done_n = 1'b1;
            rx_st_n   = RX_IDLE;
          end else begin
            rx_st_n = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        rx_cnt_n = '0;
        if (rx_s2) rx_st_n = RX_IDLE;
      end
      default: rx_st_n = RX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_txrx_top.sv
// Scoreboard bench for uart_txrx_top: line decoder on tx plus
// rx_done monitor, both popping expected bytes queued at issue time.
module tb_uart_txrx_top;
  localparam int CPB = 16;

  logic       clk = 0;
  logic       rst;
  logic       rx;
  logic       tx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_start;
  logic [7:0] tx_data_in;
  logic       tx_busy;
  logic       tx_done;

  logic loop;
  logic rx_drv;
  assign rx = loop ? tx : rx_drv;

  uart_txrx_top #(
    .CLK_FREQ (1600000),
    .BAUD_RATE(100000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .tx        (tx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .tx_start  (tx_start),
    .tx_data_in(tx_data_in),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #20 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] last_rx;
  int rx_cnt = 0;
  int drops = 0;
  bit watch = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    tx_data_in = b;
    tx_start = 1;
    txq.push_back(b);
    rxq.push_back(b);
    last_rx = b;
    cyc(1);
    tx_start = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (tx_done !== 1'b1 && n < 12 * CPB) begin
      cyc(1);
      n++;
    end
    if (tx_done !== 1'b1) fail("tx_done_timeout", "no tx_done seen");
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    rx_drv = 0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      cyc(CPB);
    end
    rx_drv = stop;
    cyc(CPB);
    rx_drv = 1;
  endtask

  always begin
    @(negedge clk);
    #2;
    if (rx_done === 1'b1) begin
      rx_cnt++;
      if (rxq.size() == 0)
        fail("rx_unexpected", $sformatf("got %0h want none", rx_data));
      else
        chk("rx_data", rx_data, rxq.pop_front());
    end
  end

  bit         tx_act = 0;
  int         mcyc;
  logic [7:0] mbyte;
  bit         frame_ok;
  bit         busy_ok;

  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      tx_act = 0;
    end else begin
      if (watch && tx_busy !== 1'b1) drops++;
      if (!tx_act) begin
        if (tx_done === 1'b1) fail("tx_done_idle", "got 1 want 0");
        if (tx === 1'b0) begin
          tx_act = 1;
          mcyc = 0;
          mbyte = '0;
          frame_ok = 1;
          busy_ok = 1;
        end
      end else begin
        mcyc++;
      end
      if (tx_act) begin
        if (mcyc % CPB == CPB / 2) begin
          if (mcyc / CPB == 0) begin
            if (tx !== 1'b0) frame_ok = 0;
          end else if (mcyc / CPB <= 8) begin
            mbyte[mcyc/CPB-1] = tx;
          end else if (tx !== 1'b1) begin
            frame_ok = 0;
          end
        end
        if (tx_done === 1'b1) begin
          if (tx_busy !== tx_start) busy_ok = 0;
          chk("tx_len", mcyc, 10 * CPB - 1);
          chk("tx_framing", frame_ok, 1);
          chk("tx_busy", busy_ok, 1);
          if (txq.size() == 0)
            fail("tx_unexpected", $sformatf("got %0h want none", mbyte));
          else
            chk("tx_byte", mbyte, txq.pop_front());
          tx_act = 0;
        end else if (tx_busy !== 1'b1 || mcyc >= 11 * CPB) begin
          busy_ok = 0;
          if (mcyc >= 11 * CPB) begin
            fail("tx_frame_timeout", "frame never ended");
            tx_act = 0;
          end
        end
      end
    end
  end

  initial begin
    #(40 * 30000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    rst = 1;
    tx_start = 0;
    tx_data_in = 8'h00;
    loop = 1;
    rx_drv = 1;
    last_rx = 8'h00;
    cyc(3);
    chk("rst_tx", tx, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_done", rx_done, 0);
    rst = 0;
    cyc(4);

    send(8'hAB);
    wait_done();
    cyc(2 * CPB);
    chk("ab_rxq", rxq.size(), 0);

    send(8'h00);
    watch = 1;
    wait_done();
    send(8'hFF);
    wait_done();
    send(8'h55);
    wait_done();
    watch = 0;
    cyc(2 * CPB);
    chk("b2b_busy_drops", drops, 0);
    chk("b2b_rxq", rxq.size(), 0);

    send(8'hA5);
    cyc(3 * CPB);
    tx_data_in = 8'h3C;
    tx_start = 1;
    cyc(1);
    tx_start = 0;
    wait_done();
    cyc(2 * CPB);
    chk("busy_ign_rxq", rxq.size(), 0);
    chk("busy_ign_data", rx_data, 8'hA5);

    loop = 0;
    r0 = rx_cnt;
    rx_frame(8'h81, 1'b0);
    rx_drv = 0;
    cyc(2 * CPB);
    rx_drv = 1;
    cyc(2 * CPB);
    chk("ferr_no_done", rx_cnt - r0, 0);
    chk("ferr_hold", rx_data, last_rx);
    rxq.push_back(8'h42);
    last_rx = 8'h42;
    rx_frame(8'h42, 1'b1);
    cyc(2 * CPB);
    chk("ferr_recover", rxq.size(), 0);

    r0 = rx_cnt;
    rx_drv = 0;
    cyc(CPB / 2 - 2);
    rx_drv = 1;
    cyc(3 * CPB);
    chk("glitch_no_done", rx_cnt - r0, 0);
    chk("glitch_hold", rx_data, 8'h42);
    loop = 1;
    send(8'h17);
    wait_done();
    cyc(2 * CPB);
    chk("glitch_recover", rxq.size(), 0);

    send(8'hC3);
    cyc(4 * CPB);
    rst = 1;
    txq.delete();
    rxq.delete();
    cyc(1);
    chk("mrst_tx", tx, 1);
    chk("mrst_busy", tx_busy, 0);
    chk("mrst_rx_data", rx_data, 8'h00);
    chk("mrst_tx_done", tx_done, 0);
    rst = 0;
    cyc(2 * CPB);
    send(8'h5A);
    wait_done();
    cyc(2 * CPB);
    chk("mrst_rxq", rxq.size(), 0);
    chk("mrst_data", rx_data, 8'h5A);
    chk("txq_left", txq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
